mem_interconnect: RTL and testbench
===================================

# mem_interconnect

Parametrised memory-bus interconnect that sits between `core` and every memory-mapped target (RAM, SPI flash, UART registers, external iomem). It replaces the hard-wired address compare and combinational rdata/ready mux with a table-driven decoder over `NUM_SLAVES` ports. It registers the request and the response and adds a per-transaction timeout. Unmapped or timed-out accesses complete with an error word and are logged.

## Interface
- `NUM_SLAVES`, 4: number of slave ports, 1..16.
- `SLAVE_BASE`, all zero: `NUM_SLAVES*32` bits; slave i base address is `[32*i +: 32]`.
- `SLAVE_MASK`, all zero: `NUM_SLAVES*32` bits; slave i matches when `(addr & mask_i) == base_i`.
- `TIMEOUT`, 1024: cycles a slave may hold the bus before an error; 0 disables the timeout.
- `ERR_RDATA`, 32'hDEADBEEF: read data returned on an error.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset; one clock; asynchronous, active-low.
- `mem_valid` in 1: master request.
- `mem_ready` out 1: master completion, a one-cycle pulse.
- `mem_addr` in 32: master address.
- `mem_wdata` in 32: master write data.
- `mem_wstrb` in 4: master byte strobes; 0 means read.
- `mem_rdata` out 32: registered read data.
- `s_valid` out NUM_SLAVES: one-hot slave request.
- `s_ready` in NUM_SLAVES: slave completion.
- `s_addr` out 32: registered address, shared by all slaves.
- `s_wdata` out 32: registered write data, shared.
- `s_wstrb` out 4: registered strobes, shared.
- `s_rdata` in NUM_SLAVES*32: slave read data, slave i at `[32*i +: 32]`.
- `bus_err` out 1: one-cycle pulse when an access completes with an error.
- `err_addr` out 32: address of the most recent errored access.
- `err_count` out 8: number of errors, saturating at 255.

## Operation
- FSM states: IDLE, ACTIVE, RESP.
- **IDLE**
  - When `mem_valid` is high, decode `mem_addr`. The lowest-index matching slave wins.
  - On a hit: latch addr, wdata, wstrb and the slave index; clear the timer; go to ACTIVE.
  - On a miss: load `ERR_RDATA`; set the error flag; go to RESP.
- **ACTIVE**
  - `s_valid[sel]` is high; all other `s_valid` bits are low.
  - When `s_ready[sel]` is high: capture `s_rdata[sel]` into `mem_rdata`; go to RESP.
  - Otherwise the timer increments. When `TIMEOUT != 0` and the timer reaches `TIMEOUT-1` with no ready, load `ERR_RDATA`, set the error flag and go to RESP.
  - `s_ready` from a slave that is not selected is ignored.
- **RESP**
  - `mem_ready` is high for one cycle.
  - If the error flag is set: pulse `bus_err`, load `err_addr` with the latched address, increment `err_count` (saturating).
  - Always return to IDLE.
- `mem_valid` may be high again in the cycle after `mem_ready`; it is decoded as a new request.
- `mem_valid` dropping during ACTIVE is a protocol violation. The transaction still completes; no abort.
- Writes that hit an error return `ERR_RDATA` as well; the master ignores it.
- On error, `mem_rdata` holds `ERR_RDATA` until the next response.

## Timing
- Reset values: state IDLE; `s_valid` 0; `mem_ready` 0; `mem_rdata`, `s_addr`, `s_wdata`, `s_wstrb` 0; `bus_err` 0; `err_addr` 0; `err_count` 0; timer 0.
- Asserting reset mid-transaction drops `s_valid` immediately and returns the FSM to IDLE. The master is never given a ready for that access.
- Mapped access, slave ready combinational: `mem_valid` at cycle 0, `s_valid` at 1, `mem_ready` at 2. The latency is 2 + the slave's wait cycles.
- Unmapped access: `mem_ready` at cycle 1.
- Timeout with `TIMEOUT=T`: `s_valid` is high for exactly T cycles, then `mem_ready` and `bus_err` follow in the next cycle.
- `s_ready` arriving in the same cycle the timer expires: ready wins; no error.
- All outputs are registered; there is no combinational path from the master to the slaves.

## Structure
- The shared package holds:
  - the FSM state encoding (2 bits);
  - the default `ERR_RDATA`;
  - the error-counter width constant (8).
- Sub-module `bus_addr_decode`:
  - purely combinational;
  - parameters `NUM_SLAVES`, `SLAVE_BASE`, `SLAVE_MASK`;
  - input `addr`; outputs `hit` and a `$clog2`-width `idx`;
  - implements the lowest-index-wins priority.
- The timer width is `$clog2(TIMEOUT+1)`, with a minimum of 1.

## Test plan
- Map RAM at base 0, mask 32'hFFFFFC00 and UART at 32'h02000004, mask 32'hFFFFFFFF. Read 32'h10 with RAM returning 32'h12345678 and a combinational ready -> `s_valid[0]` at cycle 1, `mem_rdata`=32'h12345678 with `mem_ready` at cycle 2.
- Write 32'hCAFEF00D, wstrb 4'b0011, to 32'h02000004 with the slave ready after 3 waits -> `s_wstrb`=4'b0011 and `s_wdata` as written, `s_valid[1]` high for 4 cycles, one `mem_ready` pulse, no `bus_err`.
- Read the unmapped 32'h04000000 -> `mem_ready` at cycle 1, `mem_rdata`=32'hDEADBEEF, `bus_err` pulse, `err_addr`=32'h04000000, `err_count`=1.
- With `TIMEOUT`=8 and a slave that never readies -> `s_valid` high for exactly 8 cycles, then error completion. A second case with ready on the 8th cycle -> normal data, no error.
- Make slaves 0 and 1 both match 32'h100 -> only `s_valid[0]` asserts.
- Assert `resetn` low during ACTIVE -> `s_valid` drops asynchronously and all outputs return to reset values. A request after release completes normally, and `err_count` reads 0.

Source files
------------

// File: rtl/mem_interconnect_pkg.sv
// Shared types and constants for the memory-bus interconnect.
package mem_interconnect_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEADBEEF;
  localparam int          ERR_COUNT_W       = 8;

  // Width of a slave index; a single-slave bus still needs one bit.
  function automatic int idx_width(input int num_slaves);
    return (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

  // Width of the per-transaction timer, never narrower than one bit.
  function automatic int timer_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Table-driven address decoder: base/mask compare per slave, lowest index wins.
module bus_addr_decode
  import mem_interconnect_pkg::*;
#(
  parameter int                       NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = '0
) (
  input  logic [31:0]                        addr,
  output logic                               hit,
  output logic [idx_width(NUM_SLAVES)-1:0]   idx
);

  localparam int IDX_W = idx_width(NUM_SLAVES);

  // Scan from the highest index down so the lowest matching slave is the last writer.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_interconnect.sv
// Registered memory-bus interconnect: decodes the master address onto one of
// NUM_SLAVES ports, returns registered read data, and turns unmapped or
// stalled accesses into error completions that are logged.
module mem_interconnect
  import mem_interconnect_pkg::*;
#(
  parameter int                       NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = '0,
  parameter int                       TIMEOUT    = 1024,
  parameter logic [31:0]              ERR_RDATA  = DEFAULT_ERR_RDATA
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [31:0]                mem_addr,
  input  logic [31:0]                mem_wdata,
  input  logic [3:0]                 mem_wstrb,
  output logic [31:0]                mem_rdata,
  output logic [NUM_SLAVES-1:0]      s_valid,
  input  logic [NUM_SLAVES-1:0]      s_ready,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wstrb,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata,
  output logic                       bus_err,
  output logic [31:0]                err_addr,
  output logic [ERR_COUNT_W-1:0]     err_count
);

  localparam int                   IDX_W        = idx_width(NUM_SLAVES);
  localparam int                   TIMER_W      = timer_width(TIMEOUT);
  localparam bit                   TIMEOUT_EN   = (TIMEOUT != 0);
  localparam int                   TIMER_LAST   = TIMEOUT_EN ? TIMEOUT - 1 : 0;
  localparam logic [TIMER_W-1:0]   TIMER_LAST_V = TIMER_W'(TIMER_LAST);

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   sel;
  logic [TIMER_W-1:0] timer;
  logic               err_flag;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic               sel_ready;
  logic [31:0]        sel_rdata;
  logic               timeout_hit;

  bus_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .addr (mem_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Pick the ready and read data of the selected slave; the others are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == IDX_W'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  assign timeout_hit = TIMEOUT_EN && (timer == TIMER_LAST_V);

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a ready on the last timer cycle still beats the timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          state_next = dec_hit ? ACTIVE : RESP;
        end
      end
      ACTIVE: begin
        if (sel_ready || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded only from flops, so nothing from the master reaches a slave combinationally.
  always_comb begin
    s_valid   = '0;
    mem_ready = 1'b0;
    bus_err   = 1'b0;
    case (state)
      ACTIVE: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          s_valid[i] = (sel == IDX_W'(i));
        end
      end
      RESP: begin
        mem_ready = 1'b1;
        bus_err   = err_flag;
      end
      default: begin
      end
    endcase
  end

  // Request/response datapath, timer and error log. The address is latched on
  // misses too so the RESP cycle can log it from one place.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_rdata <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      sel       <= '0;
      timer     <= '0;
      err_flag  <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_valid) begin
            s_addr  <= mem_addr;
            s_wdata <= mem_wdata;
            s_wstrb <= mem_wstrb;
            timer   <= '0;
            if (dec_hit) begin
              sel      <= dec_idx;
              err_flag <= 1'b0;
            end else begin
              mem_rdata <= ERR_RDATA;
              err_flag  <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (sel_ready) begin
            mem_rdata <= sel_rdata;
          end else if (timeout_hit) begin
            mem_rdata <= ERR_RDATA;
            err_flag  <= 1'b1;
          end else if (TIMEOUT_EN) begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (err_flag) begin
            err_addr <= s_addr;
            if (err_count != '1) begin
              err_count <= err_count + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_interconnect.sv
// Self-checking bench for mem_interconnect: a fixed vector table, a reset
// sequence, then randomized traffic predicted from the address map.
module tb_mem_interconnect;

  localparam int          NS  = 4;
  localparam int          T   = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
  // slave 0 RAM, slave 1 UART, slave 2 overlaps RAM, slave 3 overlaps UART
  localparam logic [NS*32-1:0] BASES = {32'h02000000, 32'h00000100, 32'h02000004, 32'h00000000};
  localparam logic [NS*32-1:0] MASKS = {32'hFF000000, 32'hFFFFFF00, 32'hFFFFFFFF, 32'hFFFFFC00};

  logic              clk = 1'b0;
  logic              resetn;
  logic              mem_valid;
  logic              mem_ready;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;
  logic [NS-1:0]     s_valid;
  logic [NS-1:0]     s_ready;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic [NS*32-1:0]  s_rdata;
  logic              bus_err;
  logic [31:0]       err_addr;
  logic [7:0]        err_count;

  int          pass_count  = 0;
  int          check_count = 0;
  int          cur_wait    = 0;
  logic [31:0] cur_rdata   = '0;
  logic [NS-1:0] noise     = '0;
  int          slave_cnt [NS];
  logic [31:0] m_err_addr  = '0;
  int          m_err_count = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          wait_n;
    logic [31:0] rbase;
    logic [3:0]  noise;
    int          e_sel;
    int          e_lat;
    int          e_svc;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs [9];

  mem_interconnect #(
    .NUM_SLAVES (NS),
    .SLAVE_BASE (BASES),
    .SLAVE_MASK (MASKS),
    .TIMEOUT    (T),
    .ERR_RDATA  (ERR)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_rdata   (s_rdata),
    .bus_err   (bus_err),
    .err_addr  (err_addr),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Each slave counts how long its request has been waiting.
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      slave_cnt[i] <= s_valid[i] ? slave_cnt[i] + 1 : 0;
    end
  end

  // Slave responses: ready after cur_wait cycles, spurious ready while unselected.
  always_comb begin
    s_ready = '0;
    s_rdata = '0;
    for (int i = 0; i < NS; i++) begin
      s_ready[i]          = s_valid[i] ? (slave_cnt[i] == cur_wait) : noise[i];
      s_rdata[32*i +: 32] = cur_rdata ^ (32'(i) << 28);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Address map as the system sees it; -1 means unmapped.
  function automatic int model_sel(input logic [31:0] a);
    if ((a & 32'hFFFFFC00) == 32'h0)        return 0;
    if (a == 32'h02000004)                 return 1;
    if ((a & 32'hFFFFFF00) == 32'h100)      return 2;
    if ((a & 32'hFF000000) == 32'h02000000) return 3;
    return -1;
  endfunction

  // Expected outcome of one access from the map, the slave wait and the timeout.
  function automatic void predict(input logic [31:0] a, input int w, input logic [31:0] rbase,
                                  output int sel, output int lat, output int svc,
                                  output logic [31:0] rd, output logic err);
    sel = model_sel(a);
    if (sel < 0) begin
      lat = 1; svc = 0; rd = ERR; err = 1'b1;
    end else if (w < T) begin
      lat = w + 2; svc = w + 1; rd = rbase ^ (32'(sel) << 28); err = 1'b0;
    end else begin
      lat = T + 1; svc = T; rd = ERR; err = 1'b1;
    end
  endfunction

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                               input int w, input logic [31:0] rbase, input logic [3:0] nz, input bit drop,
                               input int e_sel, input int e_lat, input int e_svc,
                               input logic [31:0] e_rdata, input logic e_err);
    int          cycles = 0;
    int          svc = 0;
    bit          onehot_bad = 0;
    bit          early_err = 0;
    bit          done = 0;
    bit          seen = 0;
    logic [31:0] got_rd = '0;
    logic        got_err = 1'b0;
    logic [31:0] cap_addr = '0;
    logic [31:0] cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;
    logic [NS-1:0] exp_sv = '0;
    if (e_sel >= 0) exp_sv = NS'(1) << e_sel;
    cur_wait  = w;
    cur_rdata = rbase;
    noise     = nz;
    @(negedge clk);
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_valid = 1'b1;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (s_valid != '0) begin
        svc++;
        if (s_valid != exp_sv) onehot_bad = 1;
        if (!seen) begin
          seen = 1; cap_addr = s_addr; cap_wdata = s_wdata; cap_wstrb = s_wstrb;
        end
      end
      if (bus_err && !mem_ready) early_err = 1;
      if (mem_ready) begin
        done = 1; got_rd = mem_rdata; got_err = bus_err;
      end
      if (drop && cycles == 1) mem_valid = 1'b0;
    end
    mem_valid = 1'b0;
    checkOutput("completed", 32'(done), 32'd1);
    checkOutput("latency", 32'(cycles), 32'(e_lat));
    checkOutput("s_valid_cycles", 32'(svc), 32'(e_svc));
    checkOutput("s_valid_onehot", 32'(onehot_bad), 32'd0);
    checkOutput("bus_err_without_ready", 32'(early_err), 32'd0);
    checkOutput("mem_rdata", got_rd, e_rdata);
    checkOutput("bus_err", 32'(got_err), 32'(e_err));
    if (e_sel >= 0) begin
      checkOutput("s_addr", cap_addr, addr);
      checkOutput("s_wdata", cap_wdata, wdata);
      checkOutput("s_wstrb", 32'(cap_wstrb), 32'(wstrb));
    end
    if (e_err) begin
      m_err_count = (m_err_count < 255) ? m_err_count + 1 : 255;
      m_err_addr  = addr;
    end
    @(negedge clk);
    checkOutput("ready_pulse_width", 32'(mem_ready), 32'd0);
    checkOutput("err_addr", err_addr, m_err_addr);
    checkOutput("err_count", 32'(err_count), 32'(m_err_count));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] rd;
    logic        er;
    int          sel, lat, svc, w, kind;
    bit          seen_ready;

    vecs[0] = '{32'h00000010, 32'h0,        4'b0000, 0,   32'h12345678, 4'hE, 0,  2, 1, 32'h12345678, 1'b0};
    vecs[1] = '{32'h02000004, 32'hCAFEF00D, 4'b0011, 3,   32'h55AA0001, 4'h0, 1,  5, 4, 32'h45AA0001, 1'b0};
    vecs[2] = '{32'h04000000, 32'h0,        4'b0000, 0,   32'h0,        4'hF, -1, 1, 0, 32'hDEADBEEF, 1'b1};
    vecs[3] = '{32'h00000020, 32'h0,        4'b0000, 255, 32'h11111111, 4'h0, 0,  9, 8, 32'hDEADBEEF, 1'b1};
    vecs[4] = '{32'h00000024, 32'h0,        4'b0000, 7,   32'h77777777, 4'hE, 0,  9, 8, 32'h77777777, 1'b0};
    vecs[5] = '{32'h00000100, 32'h0,        4'b0000, 1,   32'hA0000100, 4'h0, 0,  3, 2, 32'hA0000100, 1'b0};
    vecs[6] = '{32'h02000004, 32'h0,        4'b0000, 0,   32'h0BADC0DE, 4'h9, 1,  2, 1, 32'h1BADC0DE, 1'b0};
    vecs[7] = '{32'h02000010, 32'h0,        4'b0000, 2,   32'h00000333, 4'h7, 3,  4, 3, 32'h30000333, 1'b0};
    vecs[8] = '{32'h00000400, 32'h0,        4'b0000, 0,   32'h0,        4'h0, -1, 1, 0, 32'hDEADBEEF, 1'b1};

    resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_s_valid", 32'(s_valid), 32'd0);
    checkOutput("reset_mem_ready", 32'(mem_ready), 32'd0);
    checkOutput("reset_mem_rdata", mem_rdata, 32'd0);
    checkOutput("reset_err_count", 32'(err_count), 32'd0);
    checkOutput("reset_s_wstrb", 32'(s_wstrb), 32'd0);
    resetn = 1'b1;

    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].wait_n, vecs[i].rbase,
                    vecs[i].noise, 1'b0, vecs[i].e_sel, vecs[i].e_lat, vecs[i].e_svc,
                    vecs[i].e_rdata, vecs[i].e_err);
    end

    $display("[TB] reset during ACTIVE");
    cur_wait = 255; noise = '0;
    @(negedge clk);
    mem_addr = 32'h40; mem_wstrb = 4'b0000; mem_valid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_pre_s_valid", 32'(s_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    checkOutput("rst_s_valid", 32'(s_valid), 32'd0);
    checkOutput("rst_mem_ready", 32'(mem_ready), 32'd0);
    checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
    checkOutput("rst_mem_rdata", mem_rdata, 32'd0);
    checkOutput("rst_s_addr", s_addr, 32'd0);
    checkOutput("rst_err_addr", err_addr, 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    mem_valid = 1'b0;
    m_err_count = 0; m_err_addr = '0;
    @(negedge clk);
    resetn = 1'b1;
    seen_ready = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_ready) seen_ready = 1;
    end
    checkOutput("rst_no_ready", 32'(seen_ready), 32'd0);
    applyStimulus(32'h44, 32'h0, 4'b0000, 1, 32'h0000C0DE, 4'h0, 1'b0, 0, 3, 2, 32'h0000C0DE, 1'b0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: a = 32'($urandom_range(0, 1023)) & 32'hFFFFFFFC;
        1: a = 32'h02000004;
        2: a = 32'h00000100 | 32'($urandom_range(0, 255));
        3: a = 32'h02000000 | ($urandom & 32'h00FFFFFF);
        default: a = $urandom;
      endcase
      w  = $urandom_range(0, 9);
      rd = $urandom;
      predict(a, w, rd, sel, lat, svc, rd, er);
      applyStimulus(a, $urandom, 4'($urandom_range(0, 15)), w, cur_rdata_seed(rd, sel),
                    4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), sel, lat, svc, rd, er);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  // Recover the slave data seed that yields the predicted read data for a hit.
  function automatic logic [31:0] cur_rdata_seed(input logic [31:0] rd, input int sel);
    if (sel < 0 || rd == ERR) return rd;
    return rd ^ (32'(sel) << 28);
  endfunction

endmodule
